// File: rtl/div_unit.sv
// div_unit: 32-step restoring divider for DIV/DIVU, quotient to LO and remainder to HI.
// Ports: clk/rst (async active-high); start, sign_op, dividend, divisor are the request;
// busy is high while iterating; done pulses for one cycle with final q (quotient) and r (remainder).
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH) + 1;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic             r_sign;
  logic [WIDTH-1:0] w_in_mag;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;
  logic             w_last;
  // The quotient register starts out holding the dividend magnitude; its top bit is
  // shifted into the partial remainder each step while quotient bits fill in from the bottom.
  always_comb begin
    w_in_mag  = (sign_op && dividend[WIDTH-1]) ? -dividend : dividend;
    w_dvd_neg = r_sign & r_dividend[WIDTH-1];
    w_dvs_neg = r_sign & r_divisor[WIDTH-1];
    w_dvs_mag = w_dvs_neg ? -r_divisor : r_divisor;
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_shift - {1'b0, w_dvs_mag};
    w_ge      = ~w_diff[WIDTH];
    w_rem_n   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_n   = {r_quo[WIDTH-2:0], w_ge};
    // A zero divisor yields an all-ones quotient regardless of mode; the remainder
    // already equals the dividend because every step subtracts nothing.
    w_q_fin   = (w_dvs_mag == '0) ? '1 : (w_dvd_neg ^ w_dvs_neg) ? -w_quo_n : w_quo_n;
    w_r_fin   = w_dvd_neg ? -w_rem_n : w_rem_n;
    w_last    = r_cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_sign     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      q          <= '0;
      r          <= '0;
    end else if (r_state != RUN && start) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= w_in_mag;
      r_dividend <= dividend;
      r_divisor  <= divisor;
      r_sign     <= sign_op;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else if (r_state == RUN) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_state <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        q       <= w_q_fin;
        r       <= w_r_fin;
      end
    end else begin
      r_state <= IDLE;
      done    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard-driven bench for div_unit.
module tb_div_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        sign_op = 0;
  logic [31:0] dividend = 0;
  logic [31:0] divisor = 0;
  logic        busy, done;
  logic [31:0] q, r;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_r[$];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .sign_op(sign_op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .q(q), .r(r)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er);
    if (b == 0) begin
      eq = 32'hFFFFFFFF; er = a;
    end else if (!s) begin
      eq = a / b; er = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      eq = 32'h80000000; er = 0;
    end else begin
      eq = $signed(a) / $signed(b); er = $signed(a) % $signed(b);
    end
  endfunction

  // Drives a one-cycle start; returns at the falling edge after the accepting edge E.
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
    logic [31:0] eq, er;
    @(negedge clk);
    start = 1; sign_op = s; dividend = a; divisor = b;
    if (push) begin
      model(s, a, b, eq, er);
      exp_q.push_back(eq); exp_r.push_back(er);
    end
    @(negedge clk);
    start = 0;
  endtask

  // Counts falling edges until done, with a bounded budget.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1; start = 1; dividend = 20; divisor = 3;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {busy, done}); end
    checks++; if ({q, r} !== 64'h0) begin errors++; $display("FAIL reset_qr got q=%h r=%h want 0 0", q, r); end
    start = 0; rst = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy=%b want 0", busy); end
  endtask

  task automatic test_unsigned;
    int lat, bc;
    logic [31:0] a, b, gq, gr;
    start_op(0, 100, 7, 1);
    wait_done(lat, bc);
    gq = exp_q.pop_front(); gr = exp_r.pop_front();
    checks++; if (lat !== 32) begin errors++; $display("FAIL udiv_latency got %0d want 32", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL udiv_busy_cycles got %0d want 32", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL udiv_busy_in_done got %b want 0", busy); end
    checks++; if ({q, r} !== {gq, gr} || gq !== 32'hE || gr !== 32'h2) begin errors++; $display("FAIL udiv_100_7 got q=%h r=%h want q=%h r=%h", q, r, gq, gr); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL udiv_done_pulse done=%b busy=%b want 0 0", done, busy); end
    checks++; if ({q, r} !== {gq, gr}) begin errors++; $display("FAIL udiv_hold got q=%h r=%h want q=%h r=%h", q, r, gq, gr); end
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = (i == 0) ? 32'h1 : ($urandom >> (i * 7));
      start_op(0, a, b, 1);
      wait_done(lat, bc);
      gq = exp_q.pop_front(); gr = exp_r.pop_front();
      checks++; if ({q, r} !== {gq, gr}) begin errors++; $display("FAIL udiv_rand %h/%h got q=%h r=%h want q=%h r=%h", a, b, q, r, gq, gr); end
    end
  endtask

  task automatic test_signed;
    int lat, bc;
    logic [31:0] a, b, gq, gr;
    logic [31:0] va[4] = '{32'hFFFFFFF9, 32'h7, 32'hFFFFFF9C, 32'h7FFFFFFF};
    logic [31:0] vb[4] = '{32'h2, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h80000000};
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? va[i] : $urandom;
      b = (i < 4) ? vb[i] : ($urandom >> (i * 3));
      start_op(1, a, b, 1);
      wait_done(lat, bc);
      gq = exp_q.pop_front(); gr = exp_r.pop_front();
      checks++; if ({q, r} !== {gq, gr}) begin errors++; $display("FAIL sdiv %h/%h got q=%h r=%h want q=%h r=%h", a, b, q, r, gq, gr); end
    end
  endtask

  task automatic test_special;
    int lat, bc;
    logic [31:0] gq, gr;
    logic        vs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] va[4] = '{32'h80000000, 32'h12345678, 32'h80000001, 32'h0};
    logic [31:0] vb[4] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h5};
    for (int i = 0; i < 4; i++) begin
      start_op(vs[i], va[i], vb[i], 1);
      wait_done(lat, bc);
      gq = exp_q.pop_front(); gr = exp_r.pop_front();
      checks++; if (lat !== 32) begin errors++; $display("FAIL special_latency case %0d got %0d want 32", i, lat); end
      checks++; if ({q, r} !== {gq, gr}) begin errors++; $display("FAIL special case %0d %h/%h got q=%h r=%h want q=%h r=%h", i, va[i], vb[i], q, r, gq, gr); end
    end
  endtask

  task automatic test_start_ignored;
    int lat, bc;
    logic [31:0] gq, gr;
    start_op(0, 32'hFFFFFFFF, 3, 1);
    repeat (9) @(negedge clk);
    start = 1; sign_op = 0; dividend = 5; divisor = 1;
    @(negedge clk);
    start = 0;
    wait_done(lat, bc);
    gq = exp_q.pop_front(); gr = exp_r.pop_front();
    checks++; if (lat !== 22) begin errors++; $display("FAIL ignore_latency got %0d want 22 after E+10", lat); end
    checks++; if ({q, r} !== {gq, gr} || gq !== 32'h55555555) begin errors++; $display("FAIL ignore_result got q=%h r=%h want q=%h r=%h", q, r, gq, gr); end
  endtask

  task automatic test_reset_midrun;
    int lat, bc, seen;
    logic [31:0] gq, gr;
    start_op(0, 1000, 3, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++; if ({busy, done} !== 2'b00 || {q, r} !== 64'h0) begin errors++; $display("FAIL midrun_reset busy=%b done=%b q=%h r=%h want all 0", busy, done, q, r); end
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_no_done activity=%0d want 0", seen); end
    start_op(0, 9, 4, 1);
    wait_done(lat, bc);
    gq = exp_q.pop_front(); gr = exp_r.pop_front();
    checks++; if (lat !== 32 || {q, r} !== {gq, gr}) begin errors++; $display("FAIL midrun_restart lat=%0d q=%h r=%h want 32 q=%h r=%h", lat, q, r, gq, gr); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, gap;
    logic [31:0] eq, er, gq, gr;
    model(1, 32'hFFFFFF38, 32'h7, eq, er);
    repeat (3) begin exp_q.push_back(eq); exp_r.push_back(er); end
    @(negedge clk);
    start = 1; sign_op = 1; dividend = 32'hFFFFFF38; divisor = 32'h7;
    @(negedge clk);
    wait_done(lat, bc);
    gq = exp_q.pop_front(); gr = exp_r.pop_front();
    checks++; if (lat !== 32 || {q, r} !== {gq, gr}) begin errors++; $display("FAIL b2b_first lat=%0d q=%h r=%h want 32 q=%h r=%h", lat, q, r, gq, gr); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      gap = 1; bc = 0;
      while (!done && gap < 100) begin
        if (busy) bc++;
        @(negedge clk);
        gap++;
      end
      if (k == 1) start = 0;
      gq = exp_q.pop_front(); gr = exp_r.pop_front();
      checks++; if (gap !== 33 || bc !== 32 || busy !== 1'b0) begin errors++; $display("FAIL b2b_period %0d gap=%0d busy_cycles=%0d busy=%b want 33 32 0", k, gap, bc, busy); end
      checks++; if ({q, r} !== {gq, gr}) begin errors++; $display("FAIL b2b_result %0d q=%h r=%h want q=%h r=%h", k, q, r, gq, gr); end
    end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_special;
    test_start_ignored;
    test_reset_midrun;
    test_back_to_back;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
